// File: rtl/mux16_arbiter_pkg.sv
// mux16_arbiter_pkg: shared constants and FSM state encoding for the 16:1 select arbiter
package mux16_arbiter_pkg;
  localparam int NREQ = 16;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: rotating priority encoder, first set req bit at or after ptr (mod 16)
import mux16_arbiter_pkg::*;
module rr_pick16 (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [NREQ-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? SEL_W'(i) : off;
  end
  assign idx = ptr + off;
  assign any = |req;
endmodule

// File: rtl/mux16_arbiter.sv
// mux16_arbiter: round-robin owner of the 16:1 mux select with a one-cycle break-before-make gap
import mux16_arbiter_pkg::*;
module mux16_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] s
);
  state_t state, nstate;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ptr, idx;
  logic any, rel;
  rr_pick16 u_pick (.req(req), .ptr(ptr), .idx(idx), .any(any));
  always_comb begin
    rel = !req[s] || ((MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1)));
    nstate = (state == OWN) ? (rel ? GAP : OWN) : (any ? OWN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_valid <= 1'b0;
      s <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= nstate;
      gnt_valid <= (nstate == OWN);
      if (state == OWN) begin
        cnt <= cnt + 1'b1;
        if (rel) gnt <= '0;
      end else if (any) begin
        s <= idx;
        gnt <= NREQ'(1) << idx;
        ptr <= idx + 1'b1;
        cnt <= '0;
      end
    end
  end
endmodule
